// File: rtl/iro_seed_loader.sv
// Host-side seed/run sequencer for the instrumented ring oscillator: shifts a seed
// MSB-first onto bclk/bdat, runs the oscillator for a programmed number of clocks, then freezes it.
module iro_seed_loader #(
    parameter int N_STAGES = 25,
    parameter int CLK_DIV  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_STAGES-1:0] seed_in,
    input  logic [15:0]         run_cycles,
    output logic                bclk,
    output logic                bdat,
    output logic                enable,
    output logic                hold,
    output logic                busy,
    output logic                done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(N_STAGES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_ARM,
        S_RUN,
        S_FROZEN
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bits_q, bits_d;
    logic [N_STAGES-1:0] shreg_q, shreg_d;
    logic [15:0]         limit_q, limit_d;
    logic [15:0]         run_q, run_d;

    logic bclk_q, bclk_d;
    logic bdat_q, bdat_d;
    logic enable_q, enable_d;
    logic hold_q, hold_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic accept;
    assign accept = start && !abort && (state_q == S_IDLE || state_q == S_FROZEN);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        div_d   = div_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        limit_d = limit_q;
        run_d   = run_q;

        case (state_q)
            S_IDLE, S_FROZEN: begin
                if (accept) begin
                    shreg_d = seed_in;
                    limit_d = run_cycles;
                    bits_d  = BIT_W'(N_STAGES);
                    div_d   = '0;
                    state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shreg_d = shreg_q << 1;
                    bits_d  = bits_q - 1'b1;
                    state_d = (bits_q == BIT_W'(1)) ? S_ARM : S_SHIFT_LO;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_ARM: begin
                run_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // A zero limit never matches, so the counter just wraps and RUN persists.
                run_d = run_q + 16'd1;
                if (limit_q != '0 && run_d == limit_q) begin
                    state_d = S_FROZEN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Outputs are decoded from the next state and registered, so they change on the
    // same edge as the state and never depend combinationally on the inputs.
    always_comb begin
        bclk_d   = (state_d == S_SHIFT_HI);
        bdat_d   = (state_d == S_SHIFT_LO || state_d == S_SHIFT_HI) ? shreg_d[N_STAGES-1] : 1'b0;
        enable_d = (state_d == S_RUN || state_d == S_FROZEN);
        hold_d   = (state_d == S_FROZEN);
        busy_d   = !(state_d == S_IDLE || state_d == S_FROZEN);
        done_d   = (state_d == S_FROZEN) && (state_q != S_FROZEN);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            bits_q   <= '0;
            shreg_q  <= '0;
            limit_q  <= '0;
            run_q    <= '0;
            bclk_q   <= 1'b0;
            bdat_q   <= 1'b0;
            enable_q <= 1'b0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            shreg_q  <= shreg_d;
            limit_q  <= limit_d;
            run_q    <= run_d;
            bclk_q   <= bclk_d;
            bdat_q   <= bdat_d;
            enable_q <= enable_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bclk   = bclk_q;
    assign bdat   = bdat_q;
    assign enable = enable_q;
    assign hold   = hold_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_iro_seed_loader.sv
// Directed bench for iro_seed_loader (N_STAGES=25, CLK_DIV=2): receiver model on bclk rises,
// cycle-accurate timing of enable/hold/done/busy, restart, infinite run, abort and reset.
module tb_iro_seed_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [24:0] seed_in = '0;
    logic [15:0] run_cycles = '0;
    logic        bclk, bdat, enable, hold, busy, done;

    int n_cmp = 0;
    int n_fail = 0;

    iro_seed_loader #(.N_STAGES(25), .CLK_DIV(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .seed_in    (seed_in),
        .run_cycles (run_cycles),
        .bclk       (bclk),
        .bdat       (bdat),
        .enable     (enable),
        .hold       (hold),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bclk, bdat, enable, hold, busy, done};
    endfunction

    // Accept a start at the next edge (cycle 0), then watch through freeze.
    // Start pulses are injected mid-shift and mid-run with a different seed; they must be ignored.
    task automatic run_seq(input logic [24:0] seed, input logic [15:0] rc,
                           input int exp_en_first, input int exp_done, input string tag);
        int first_r = -1, last_r = -1, n_rise = 0;
        int en_first = -1, en_cnt = 0, done_cnt = 0, done_cyc = -1, busy_fall = -1;
        int bad_bdat = 0;
        logic hold_at_done = 1'b0;
        logic [24:0] rx = '0;
        logic pbclk, pbdat, pbusy;
        int cyc;
        seed_in    = seed;
        run_cycles = rc;
        start      = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " cycle1 busy/enable/hold"}, {29'd0, busy, enable, hold}, 32'h4);
        pbclk = 1'b0;
        pbdat = bdat;
        pbusy = 1'b1;
        while (cyc <= exp_done + 2) begin
            if (bclk && !pbclk) begin
                n_rise++;
                rx = {rx[23:0], bdat};
                if (first_r < 0) first_r = cyc;
                last_r = cyc;
            end
            if (bdat != pbdat && bclk) bad_bdat++;
            if (enable && !hold) en_cnt++;
            if (enable && en_first < 0) en_first = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                hold_at_done = hold;
            end
            if (!busy && pbusy && busy_fall < 0) busy_fall = cyc;
            pbclk = bclk;
            pbdat = bdat;
            pbusy = busy;
            start   = (cyc == 53 || cyc == exp_done - 2);
            seed_in = ~seed;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " rise count"}, n_rise, 25);
        check({tag, " received seed"}, {7'd0, rx}, {7'd0, seed});
        check({tag, " first rise cycle"}, first_r, 3);
        check({tag, " last rise cycle"}, last_r, 99);
        check({tag, " bdat changes while bclk high"}, bad_bdat, 0);
        check({tag, " enable first cycle"}, en_first, exp_en_first);
        check({tag, " enable clocks with hold low"}, en_cnt, {16'd0, rc});
        check({tag, " done pulse count"}, done_cnt, 1);
        check({tag, " done cycle"}, done_cyc, exp_done);
        check({tag, " hold at done"}, {31'd0, hold_at_done}, 1);
        check({tag, " busy fall cycle"}, busy_fall, exp_done);
    endtask

    initial begin
        int bad;
        int waited;

        // Reset state
        #2;
        check("reset outputs", {26'd0, outs()}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", {26'd0, outs()}, 0);

        // Seed shift and run/freeze
        run_seq(25'h0AAAAAA, 16'd10, 102, 112, "seqA");
        repeat (5) @(negedge clk);
        check("frozen steady outputs", {26'd0, outs()}, 32'h0C);

        // Restart from FROZEN: enable/hold drop on the accepting edge
        run_seq(25'h1555555, 16'd3, 102, 105, "seqB");

        // Infinite run
        seed_in    = 25'h0123456;
        run_cycles = 16'd0;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("inf enable low at cycle 101", {31'd0, enable}, 0);
        @(negedge clk);
        check("inf enable high at cycle 102", {31'd0, enable}, 1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!enable || hold || done || !busy) bad++;
            @(negedge clk);
        end
        check("inf run steady", bad, 0);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort outputs zero", {26'd0, outs()}, 0);

        // Abort/start collision in IDLE
        bad   = 0;
        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bclk || busy || bdat) bad++;
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        if (bclk || busy) bad++;
        check("collision stays idle", bad, 0);

        // Asynchronous reset mid-SHIFT_HI
        seed_in    = 25'h1FFFFFF;
        run_cycles = 16'd5;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!bclk && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("reached SHIFT_HI", {31'd0, bclk}, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset outputs", {26'd0, outs()}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (outs() != 6'd0) bad++;
        end
        check("idle after async reset", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
